clb_tile: RTL and testbench
===========================

Name: clb_tile

Overview:
- Single configurable logic block tile of the simple FPGA fabric.
- Four 1-bit neighbour ports: up, down, right, left.
- Each output either passes the opposite-side input straight through or carries the output of a shared 4-input LUT.
- The LUT result is either combinational or registered.
- Configuration is a 23-bit word loaded through a write-enable strobe.

Parameters:
- CFG_W, 23, configuration word width; fixed by field map, not meant to be overridden.
- LUT_W, 16, LUT truth-table width (2^4 entries).

Ports:
- clk_i  input  1  fabric clock; config and LUT flop update on rising edge
- rst_ni  input  1  asynchronous active-low reset
- wr_en  input  1  config write strobe; sampled on rising clk_i
- bits  input  23  configuration word to load
- up_i  input  1  input from upper neighbour
- down_i  input  1  input from lower neighbour
- right_i  input  1  input from right neighbour
- left_i  input  1  input from left neighbour
- up_o  output  1  output toward upper neighbour
- down_o  output  1  output toward lower neighbour
- right_o  output  1  output toward right neighbour
- left_o  output  1  output toward left neighbour

Behaviour:
- Config register cfg[22:0] loads bits on a rising clk_i when wr_en=1 and holds otherwise. The new config takes effect from the cycle after the write edge.
- Field map:
  - cfg[22] up_sel
  - cfg[21] down_sel
  - cfg[20] right_sel
  - cfg[19] left_sel
  - cfg[18] comb_mode
  - cfg[17:16] reserved (stored, no effect, read as don't-care)
  - cfg[15:0] lut
- LUT index idx = {up_i, down_i, right_i, left_i} (up_i is the MSB). lut_comb = lut[idx].
- LUT flop lut_q <= lut_comb on every rising clk_i, regardless of wr_en.
- lut_out = comb_mode ? lut_comb : lut_q.
  - comb_mode=1: zero-latency path.
  - comb_mode=0: one-cycle latency; input changes appear at outputs after the next rising edge.
- Output muxes, all combinational:
  - up_o = up_sel ? lut_out : down_i
  - down_o = down_sel ? lut_out : up_i
  - right_o = right_sel ? lut_out : left_i
  - left_o = left_sel ? lut_out : right_i
- Direct (sel=0) paths are purely combinational and never registered.
- Reset (rst_ni=0, asynchronous) forces cfg=0 and lut_q=0. The tile therefore comes up in full pass-through mode: each output equals the opposite input, even during reset.
- If wr_en is asserted on the same edge the LUT flop samples, lut_q captures using the old lut. The new table affects lut_q from the following edge.
- Reset released mid-operation: the config must be reloaded. No partial state is retained.

Decomposition:
- Shared package clb_pkg holds:
  - field index constants (SEL_UP=22, SEL_DOWN=21, SEL_RIGHT=20, SEL_LEFT=19, COMB_BIT=18, RSVD_HI=17, RSVD_LO=16, LUT_HI=15)
  - a packed struct typedef clb_cfg_t matching the map
- One natural sub-module: clb_lut4, which contains the 16:1 table mux plus the output flop and the comb/registered select.
- Top level holds the config register and the four output muxes.

Test Plan:
- Reset then write cfg=23'b0000_0_11_0101001000110111; drive up=1, down=1, right=0, left=1 -> down_o=1, up_o=1, left_o=0, right_o=1. Then drive 0,1,1,0 -> down_o=0, up_o=1, left_o=1, right_o=0.
- Write cfg {0110,1,10,lut=16'h5A37}; inputs 1,1,0,1 (idx 13) -> down_o=right_o=lut[13]=0 with no latency, up_o=down_i=1, left_o=right_i=0. Inputs 0,0,0,1 (idx 1) -> down_o=right_o=lut[1]=1.
- Write cfg {1111,0,00,lut=16'hFF00}; inputs 1,1,0,1 -> after one edge all four outputs =1. Switch inputs to 0,0,0,1 -> outputs stay 1 until the next edge, then all =0.
- Assert rst_ni low asynchronously mid-cycle while in LUT mode -> outputs immediately become pass-through of opposite inputs; lut_q=0.
- Hold wr_en=0 and change bits -> outputs unaffected; config changes only on an edge with wr_en=1.
- Reserved bits [17:16] toggled across 00/01/10/11 with otherwise identical config -> identical outputs.

Source files
------------

// File: rtl/clb_pkg.sv
// Shared definitions for the CLB tile: configuration field positions, widths,
// the packed configuration struct and a helper that unpacks a raw word into it.
package clb_pkg;

  localparam int unsigned CFG_W = 23;  // config word width, fixed by the field map
  localparam int unsigned LUT_W = 16;  // 4-input truth table

  localparam int unsigned SEL_UP    = 22;
  localparam int unsigned SEL_DOWN  = 21;
  localparam int unsigned SEL_RIGHT = 20;
  localparam int unsigned SEL_LEFT  = 19;
  localparam int unsigned COMB_BIT  = 18;
  localparam int unsigned RSVD_HI   = 17;
  localparam int unsigned RSVD_LO   = 16;
  localparam int unsigned LUT_HI    = 15;

  typedef struct packed {
    logic             up_sel;
    logic             down_sel;
    logic             right_sel;
    logic             left_sel;
    logic             comb_mode;
    logic [1:0]       rsvd;
    logic [LUT_W-1:0] lut;
  } clb_cfg_t;

  // Unpack by named index so the struct layout and field map cannot drift apart.
  function automatic clb_cfg_t to_cfg(input logic [CFG_W-1:0] w);
    clb_cfg_t c;
    c.up_sel    = w[SEL_UP];
    c.down_sel  = w[SEL_DOWN];
    c.right_sel = w[SEL_RIGHT];
    c.left_sel  = w[SEL_LEFT];
    c.comb_mode = w[COMB_BIT];
    c.rsvd      = w[RSVD_HI:RSVD_LO];
    c.lut       = w[LUT_HI:0];
    return c;
  endfunction

endpackage

// File: rtl/clb_if.sv
// Neighbour and configuration signals of one CLB tile.
//   wr_en, bits              : config write strobe and word
//   up_i/down_i/right_i/left_i : inputs from the four neighbours
//   up_o/down_o/right_o/left_o : outputs toward the four neighbours
// master drives config and neighbour inputs; slave is the tile side.
interface clb_if;
  import clb_pkg::*;

  logic             wr_en;
  logic [CFG_W-1:0] bits;
  logic             up_i;
  logic             down_i;
  logic             right_i;
  logic             left_i;
  logic             up_o;
  logic             down_o;
  logic             right_o;
  logic             left_o;

  modport master (
    output wr_en, bits, up_i, down_i, right_i, left_i,
    input  up_o, down_o, right_o, left_o
  );

  modport slave (
    input  wr_en, bits, up_i, down_i, right_i, left_i,
    output up_o, down_o, right_o, left_o
  );

endinterface

// File: rtl/clb_lut4.sv
// Shared 4-input LUT: 16:1 table mux, output flop and comb/registered select.
//   clk_i, rst_ni : clock, async active-low reset (clears the flop)
//   lut_i         : truth table
//   idx_i         : table index {up, down, right, left}
//   comb_mode_i   : 1 = combinational result, 0 = registered result
//   lut_out_o     : selected LUT result
module clb_lut4
  import clb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [LUT_W-1:0] lut_i,
  input  logic [3:0]       idx_i,
  input  logic             comb_mode_i,
  output logic             lut_out_o
);

  logic lut_comb;
  logic lut_q;

  assign lut_comb = lut_i[idx_i];

  // Samples every edge, independent of config writes, so a write on the same
  // edge is captured with the table that was active before it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lut_q <= 1'b0;
    end else begin
      lut_q <= lut_comb;
    end
  end

  assign lut_out_o = comb_mode_i ? lut_comb : lut_q;

endmodule

// File: rtl/clb_tile.sv
// One CLB tile: config register, shared LUT and four output muxes. Each output
// carries either the opposite-side input (direct, never registered) or the LUT
// result. Reset clears the config, giving full pass-through.
//   clk_i, rst_ni : clock, async active-low reset
//   bus           : config write and neighbour ports (slave side)
module clb_tile
  import clb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  clb_if.slave bus
);

  clb_cfg_t cfg_q;
  logic     lut_out;
  logic     unused_rsvd;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= '0;
    end else if (bus.wr_en) begin
      cfg_q <= to_cfg(bus.bits);
    end
  end

  // Reserved field is stored but has no function.
  assign unused_rsvd = ^cfg_q.rsvd;

  clb_lut4 u_lut4 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .lut_i       (cfg_q.lut),
    .idx_i       ({bus.up_i, bus.down_i, bus.right_i, bus.left_i}),
    .comb_mode_i (cfg_q.comb_mode),
    .lut_out_o   (lut_out)
  );

  assign bus.up_o    = cfg_q.up_sel    ? lut_out : bus.down_i;
  assign bus.down_o  = cfg_q.down_sel  ? lut_out : bus.up_i;
  assign bus.right_o = cfg_q.right_sel ? lut_out : bus.left_i;
  assign bus.left_o  = cfg_q.left_sel  ? lut_out : bus.right_i;

endmodule

// File: tb/tb_clb_tile.sv
// Self-checking bench for clb_tile: directed scenarios plus random traffic,
// compared against a behavioural model of the tile.
module tb_clb_tile;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  clb_if bus ();

  clb_tile dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [22:0] Cfg1 = 23'b0000_0_11_0101001000110111;
  localparam logic [22:0] Cfg2 = {4'b0110, 1'b1, 2'b10, 16'h5A37};
  localparam logic [22:0] Cfg3 = {4'b1111, 1'b0, 2'b00, 16'hFF00};

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model state: the configuration word as written and the registered LUT bit.
  logic [22:0] cfg_m = '0;
  logic        lut_m = 1'b0;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // in = {up, down, right, left}; result = {up_o, down_o, right_o, left_o}
  function automatic logic [3:0] model_out(input logic [3:0] in);
    logic [15:0] table_m;
    logic        lo;
    table_m = cfg_m[15:0];
    lo = cfg_m[18] ? table_m[in] : lut_m;
    return {cfg_m[22] ? lo : in[2], cfg_m[21] ? lo : in[3],
            cfg_m[20] ? lo : in[0], cfg_m[19] ? lo : in[1]};
  endfunction

  function automatic logic [3:0] dut_out();
    return {bus.up_o, bus.down_o, bus.right_o, bus.left_o};
  endfunction

  task automatic drive(input logic wr, input logic [22:0] b, input logic [3:0] in);
    bus.wr_en = wr;
    bus.bits  = b;
    {bus.up_i, bus.down_i, bus.right_i, bus.left_i} = in;
  endtask

  // Drive after the falling edge, check before the rising edge, then advance
  // the model with the values that were present at the rising edge.
  task automatic cycle(input string tag, input logic wr, input logic [22:0] b,
                       input logic [3:0] in, output logic [3:0] obs);
    logic [15:0] table_m;
    @(negedge clk_i);
    drive(wr, b, in);
    #1;
    obs = dut_out();
    check(tag, obs, model_out(in));
    @(posedge clk_i);
    if (rst_ni) begin
      table_m = cfg_m[15:0];
      lut_m   = table_m[in];
      if (wr) cfg_m = b;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  obs;
    logic [3:0]  in;
    logic [22:0] b;

    // Reset: pass-through while reset is held.
    drive(1'b0, '0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      in = 4'(i * 5 + 3);
      drive(1'b0, 23'h7FFFFF, in);
      #2;
      check("reset_pass", dut_out(), model_out(in));
    end
    drive(1'b0, '0, 4'b1000);
    #1;
    check("reset_const", dut_out(), 4'b0100);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Pass-through configuration.
    cycle("t1_wr", 1'b1, Cfg1, 4'b0000, obs);
    cycle("t1_a", 1'b0, Cfg1, 4'b1101, obs);
    check("t1_a_const", obs, 4'b1110);
    cycle("t1_b", 1'b0, Cfg1, 4'b0110, obs);
    check("t1_b_const", obs, 4'b1001);

    // Combinational LUT on down/right.
    cycle("t2_wr", 1'b1, Cfg2, 4'b0000, obs);
    cycle("t2_a", 1'b0, Cfg2, 4'b1101, obs);
    check("t2_a_const", obs, 4'b1000);
    cycle("t2_b", 1'b0, Cfg2, 4'b0001, obs);
    check("t2_b_const", obs, 4'b0110);

    // Registered LUT on all outputs; the write edge samples the old table.
    cycle("t3_wr", 1'b1, Cfg3, 4'b1101, obs);
    cycle("t3_old_tbl", 1'b0, Cfg3, 4'b1101, obs);
    check("t3_old_tbl_const", obs, 4'b0000);
    cycle("t3_hold", 1'b0, Cfg3, 4'b0001, obs);
    check("t3_hold_const", obs, 4'b1111);
    cycle("t3_upd", 1'b0, Cfg3, 4'b0001, obs);
    check("t3_upd_const", obs, 4'b0000);
    cycle("t3_reload", 1'b0, Cfg3, 4'b1101, obs);

    // Asynchronous reset mid-cycle with lut_q=1.
    @(negedge clk_i);
    drive(1'b0, Cfg3, 4'b1101);
    #1;
    check("arst_before", dut_out(), 4'b1111);
    #2;
    rst_ni = 1'b0;
    cfg_m  = '0;
    lut_m  = 1'b0;
    #1;
    check("arst_pass", dut_out(), 4'b1110);
    drive(1'b0, Cfg3, 4'b0110);
    #1;
    check("arst_pass2", dut_out(), model_out(4'b0110));
    @(posedge clk_i);
    #1;
    check("arst_edge", dut_out(), 4'b1001);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle("arst_after", 1'b0, Cfg3, 4'b1010, obs);
    check("arst_after_const", obs, 4'b0101);

    // Writes need wr_en: changing bits alone has no effect.
    cycle("we_wr", 1'b1, Cfg2, 4'b0000, obs);
    cycle("we_hold", 1'b0, 23'h7FFFFF, 4'b1101, obs);
    check("we_hold_const", obs, 4'b1000);
    cycle("we_hold2", 1'b0, Cfg3, 4'b0001, obs);
    check("we_hold2_const", obs, 4'b0110);

    // Reserved field has no effect.
    for (int r = 0; r < 4; r++) begin
      b = Cfg2;
      b[17:16] = 2'(r);
      cycle("rsvd_wr", 1'b1, b, 4'b0000, obs);
      cycle("rsvd_a", 1'b0, b, 4'b1101, obs);
      check("rsvd_const", obs, 4'b1000);
    end

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      b  = 23'($urandom);
      in = 4'($urandom);
      cycle("rand", ($urandom_range(0, 7) == 0), b, in, obs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
